// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rng_pkg
// Brief    : Shared types, defaults and helpers for the generator arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rng_pkg;

  localparam int c_nreq_default    = 4;
  localparam int c_timeout_default = 15;
  localparam int c_cnt_w           = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DELIVER = 3'd4
  } rng_state_t;

  // Index of the set bit in a one-hot vector of up to eight requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first set req bit at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import rng_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [PW-1:0]   p);
    logic [NREQ-1:0] oh;
    logic            found;
    int              k;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(p) + i) % NREQ;
      if (!found && r[k]) begin
        oh[k] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  assign gnt = pick(req, ptr);

endmodule
`default_nettype wire

// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rng_arbiter
// Brief    : Round-robin arbiter sharing one external random generator.
// Revision : 1.0 - initial release
// ============================================================================
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int NREQ    = c_nreq_default,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] sel_4bit,
  output logic            en_rng,
  input  logic            rng_done,
  input  logic [15:0]     rng_in,
  input  logic [15:0]     rng_in_4bit,
  output logic [NREQ-1:0] gnt,
  output logic [15:0]     rnd_out,
  output logic            rnd_vld,
  output logic            rnd_err,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);

  rng_state_t           r_state;
  logic [PW-1:0]        r_ptr;
  logic                 r_sel;
  logic [c_cnt_w-1:0]   r_wait_cnt;

  logic [NREQ-1:0]      w_pick;
  logic [2:0]           w_idx;
  logic [PW-1:0]        w_ptr_next;
  logic                 w_timeout;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  assign w_idx      = onehot_to_idx(8'(gnt));
  assign w_ptr_next = (w_idx == 3'(NREQ - 1)) ? '0 : PW'(w_idx + 3'd1);
  // Asserted on the last permitted wait cycle, so the exit edge is the TIMEOUT-th.
  assign w_timeout  = (r_wait_cnt == c_cnt_w'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_sel      <= 1'b0;
      r_wait_cnt <= '0;
      gnt        <= '0;
      rnd_out    <= '0;
      rnd_vld    <= 1'b0;
      rnd_err    <= 1'b0;
      en_rng     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      en_rng  <= 1'b0;
      rnd_vld <= 1'b0;
      rnd_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_ISSUE;
            gnt     <= w_pick;
            r_sel   <= |(w_pick & sel_4bit);
            en_rng  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT_LO;
          r_wait_cnt <= '0;
        end
        S_WAIT_LO: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_timeout) begin
            r_state <= S_DELIVER;
            rnd_out <= '0;
            rnd_vld <= 1'b1;
            rnd_err <= 1'b1;
          end else if (!rng_done) begin
            r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // A genuine completion wins over a coincident timeout.
          if (rng_done) begin
            r_state <= S_DELIVER;
            rnd_out <= r_sel ? rng_in_4bit : rng_in;
            rnd_vld <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_DELIVER;
            rnd_out <= '0;
            rnd_vld <= 1'b1;
            rnd_err <= 1'b1;
          end
        end
        S_DELIVER: begin
          r_state <= S_IDLE;
          r_ptr   <= w_ptr_next;
          gnt     <= '0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
